// File: rtl/taillamp_sequence_ctrl.sv
// taillamp_sequence_ctrl: debounced START, pre-delay, per-tick step strobes over repeated passes, brake pause, 7-seg repeat digit
module taillamp_sequence_ctrl #(
  parameter int TICK_DIV  = 5_000_000,
  parameter int PRE_DELAY = 100_000_000,
  parameter int DEBOUNCE  = 1_000_000,
  parameter int NUM_STEPS = 45,
  parameter int REPEATS   = 9
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       START,
  input  logic       brake,
  output logic [5:0] step_idx,
  output logic       step_stb,
  output logic       running,
  output logic       brake_active,
  output logic       done,
  output logic [3:0] repeats_left,
  output logic [7:0] seg_n
);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int PW = $clog2(PRE_DELAY + 1);
  localparam int DW = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {IDLE, PREDELAY, RUN, PAUSE, DONE} state_t;

  state_t        state;
  logic          start_s1, start_s2, brake_s1;
  logic          start_db, press;
  logic [DW-1:0] db_cnt;
  logic [PW-1:0] pre_cnt;
  logic [TW-1:0] tick;
  logic          tick_end, last_step;

  assign tick_end  = tick == TW'(TICK_DIV - 1);
  assign last_step = step_idx == 6'(NUM_STEPS - 1);

  // Two-flop synchronisers; the second brake stage is the brake_active output
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) {start_s1, start_s2, brake_s1, brake_active} <= 4'b1100;
    else {start_s1, start_s2, brake_s1, brake_active} <= {START, start_s1, brake, brake_s1};

  // Debounce START and emit a one-cycle press on the released->pressed transition
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) begin
      start_db <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (start_s2 == start_db) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE - 1)) begin
        start_db <= start_s2;
        db_cnt   <= '0;
        press    <= !start_s2;
      end else db_cnt <= db_cnt + 1'b1;
    end

  // Sequencer: pre-delay, tick/step/repeat counting, brake pause (resume edge counts as a RUN cycle)
  always_ff @(posedge clk or negedge RESET)
    if (!RESET) begin
      state        <= IDLE;
      step_idx     <= '0;
      step_stb     <= 1'b0;
      running      <= 1'b0;
      done         <= 1'b0;
      repeats_left <= 4'(REPEATS);
      pre_cnt      <= '0;
      tick         <= '0;
    end else begin
      step_stb <= 1'b0;
      case (state)
        IDLE: if (press) begin
          state   <= PREDELAY;
          pre_cnt <= '0;
        end
        PREDELAY: if (pre_cnt == PW'(PRE_DELAY - 1)) begin
          state    <= RUN;
          running  <= 1'b1;
          step_idx <= '0;
          step_stb <= 1'b1;
          tick     <= '0;
        end else pre_cnt <= pre_cnt + 1'b1;
        RUN, PAUSE: if (brake_active) state <= PAUSE;
        else begin
          state <= RUN;
          if (!tick_end) tick <= tick + 1'b1;
          else begin
            tick <= '0;
            if (!last_step) begin
              step_idx <= step_idx + 6'd1;
              step_stb <= 1'b1;
            end else begin
              step_idx     <= '0;
              repeats_left <= repeats_left - 4'd1;
              if (repeats_left == 4'd1) begin
                state   <= DONE;
                running <= 1'b0;
                done    <= 1'b1;
              end else step_stb <= 1'b1;
            end
          end
        end
        DONE: if (press) begin
          state        <= PREDELAY;
          done         <= 1'b0;
          pre_cnt      <= '0;
          repeats_left <= 4'(REPEATS);
        end
        default: state <= IDLE;
      endcase
    end

  // Active-low 7-segment digit for repeats_left; values above 9 show a dash
  always_comb
    case (repeats_left)
      4'd0:    seg_n = 8'h40;
      4'd1:    seg_n = 8'h79;
      4'd2:    seg_n = 8'h24;
      4'd3:    seg_n = 8'h30;
      4'd4:    seg_n = 8'h19;
      4'd5:    seg_n = 8'h12;
      4'd6:    seg_n = 8'h02;
      4'd7:    seg_n = 8'h78;
      4'd8:    seg_n = 8'h00;
      4'd9:    seg_n = 8'h10;
      default: seg_n = 8'h3F;
    endcase
endmodule

// File: tb/tb_taillamp_sequence_ctrl.sv
// tb_taillamp_sequence_ctrl: directed and randomized checks of the taillamp sequencer against a behavioural model
module tb_taillamp_sequence_ctrl;
  localparam int TICK_DIV  = 4;
  localparam int PRE_DELAY = 10;
  localparam int DEBOUNCE  = 3;
  localparam int NUM_STEPS = 5;
  localparam int REPEATS   = 2;
  localparam int M_IDLE = 0, M_PRE = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       RESET, START, brake;
  logic [5:0] step_idx;
  logic       step_stb, running, brake_active, done;
  logic [3:0] repeats_left;
  logic [7:0] seg_n;

  taillamp_sequence_ctrl #(
    .TICK_DIV(TICK_DIV), .PRE_DELAY(PRE_DELAY), .DEBOUNCE(DEBOUNCE),
    .NUM_STEPS(NUM_STEPS), .REPEATS(REPEATS)
  ) dut (
    .clk(clk), .RESET(RESET), .START(START), .brake(brake),
    .step_idx(step_idx), .step_stb(step_stb), .running(running),
    .brake_active(brake_active), .done(done), .repeats_left(repeats_left), .seg_n(seg_n)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;

  logic [7:0] seg_tab [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                               8'h00, 8'h10, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: input delay lines, run-length debounce, and a run described by
  // the number of completed tick periods n_ev (step = n_ev mod N, passes left = R - n_ev/N)
  bit sq[$], bq[$];
  bit lvl, pr, pr_old, synced, brk_old, m_brk, m_stb;
  int run_len, mode, pre_left, elapsed, n_ev;

  task automatic model_reset();
    sq = '{1'b1, 1'b1};
    bq = '{1'b0, 1'b0};
    lvl = 1'b1; pr = 1'b0; m_brk = 1'b0; m_stb = 1'b0;
    run_len = 0; mode = M_IDLE; pre_left = 0; elapsed = 0; n_ev = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!RESET) model_reset();
    else begin
      synced = sq.pop_front();
      sq.push_back(START);
      brk_old = bq.pop_front();
      bq.push_back(brake);
      m_brk = bq[0];
      pr_old = pr;
      pr = 1'b0;
      if (synced != lvl) begin
        run_len++;
        if (run_len == DEBOUNCE) begin
          lvl = synced;
          run_len = 0;
          pr = !synced;
        end
      end else run_len = 0;
      m_stb = 1'b0;
      if (mode == M_IDLE || mode == M_DONE) begin
        if (pr_old) begin
          mode = M_PRE;
          pre_left = PRE_DELAY;
          n_ev = 0;
        end
      end else if (mode == M_PRE) begin
        pre_left--;
        if (pre_left == 0) begin
          mode = M_RUN;
          m_stb = 1'b1;
          elapsed = 0;
        end
      end else if (brk_old) mode = M_PAUSE;
      else begin
        mode = M_RUN;
        elapsed++;
        if (elapsed == TICK_DIV) begin
          elapsed = 0;
          n_ev++;
          if (n_ev == NUM_STEPS * REPEATS) mode = M_DONE;
          else m_stb = 1'b1;
        end
      end
    end
  end

  int stb_t[$], stb_i[$], stb_r[$];

  // Compare every cycle, just after the active edge; also log strobes for the directed checks
  always @(posedge clk) begin
    #1;
    chk("step_idx", step_idx, n_ev % NUM_STEPS);
    chk("step_stb", step_stb, m_stb);
    chk("running", running, mode == M_RUN || mode == M_PAUSE);
    chk("brake_active", brake_active, m_brk);
    chk("done", done, mode == M_DONE);
    chk("repeats_left", repeats_left, REPEATS - n_ev / NUM_STEPS);
    chk("seg_n", seg_n, seg_tab[REPEATS - n_ev / NUM_STEPS]);
    if (step_stb === 1'b1) begin
      stb_t.push_back(cyc);
      stb_i.push_back(int'(step_idx));
      stb_r.push_back(int'(repeats_left));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int e, d, f, s_hold, b_hold;

  initial begin
    RESET = 1'b0; START = 1'b1; brake = 1'b0;
    tick(3);
    RESET = 1'b1;
    tick(2);
    chk("rst_seg", seg_n, 8'h24);
    chk("rst_rep", repeats_left, 2);
    chk("rst_running", running, 0);
    chk("rst_idx", step_idx, 0);
    // Two-cycle glitch must not register as a press
    START = 1'b0;
    tick(2);
    START = 1'b1;
    tick(20);
    chk("glitch_idle", {running, done}, 0);
    chk("glitch_seg", seg_n, 8'h24);
    // Held press: full run with a second press inside RUN that must be ignored
    stb_t.delete(); stb_i.delete(); stb_r.delete();
    e = cyc + 1;
    START = 1'b0;
    tick(20);
    START = 1'b1;
    tick(10);
    START = 1'b0;
    tick(6);
    START = 1'b1;
    for (int i = 0; i < 100 && done !== 1'b1; i++) tick(1);
    chk("done_reached", done, 1);
    chk("done_cycle", cyc, e + 55);
    chk("done_seg", seg_n, 8'h40);
    chk("run_strobes", stb_t.size(), 10);
    for (int k = 0; k < 10 && k < stb_t.size(); k++) begin
      chk("stb_time", stb_t[k], e + 15 + 4 * k);
      chk("stb_idx", stb_i[k], k % 5);
    end
    if (stb_r.size() >= 6) begin
      chk("rep_before_wrap", stb_r[4], 2);
      chk("rep_after_wrap", stb_r[5], 1);
    end
    // Press in DONE restarts with a fresh repeat count
    stb_t.delete(); stb_i.delete(); stb_r.delete();
    d = cyc;
    START = 1'b0;
    tick(6);
    START = 1'b1;
    tick(4);
    chk("restart_rep", repeats_left, 2);
    chk("restart_seg", seg_n, 8'h24);
    chk("restart_done", done, 0);
    chk("restart_running", running, 0);
    for (int i = 0; i < 40 && step_stb !== 1'b1; i++) tick(1);
    chk("restart_first_stb", step_stb, 1);
    chk("restart_first_cycle", cyc, d + 16);
    f = cyc;
    // Brake lands on the tick terminal count: strobe withheld until the first RUN cycle after release
    tick(1);
    brake = 1'b1;
    tick(7);
    brake = 1'b0;
    for (int i = 0; i < 30 && step_stb !== 1'b1; i++) tick(1);
    chk("resume_stb", step_stb, 1);
    chk("resume_cycle", cyc, f + 11);
    chk("resume_idx", step_idx, 1);
    chk("pause_strobes", stb_t.size(), 2);
    // Reset mid-run at step 3, then no activity without a new press
    for (int i = 0; i < 40 && step_idx !== 6'd3; i++) tick(1);
    chk("reached_idx3", step_idx, 3);
    RESET = 1'b0;
    tick(1);
    chk("midrst_idx", step_idx, 0);
    chk("midrst_running", running, 0);
    chk("midrst_rep", repeats_left, 2);
    chk("midrst_seg", seg_n, 8'h24);
    tick(2);
    RESET = 1'b1;
    stb_t.delete(); stb_i.delete(); stb_r.delete();
    tick(60);
    chk("post_rst_strobes", stb_t.size(), 0);
    chk("post_rst_running", running, 0);
    // Randomized START, brake and occasional reset pulses
    s_hold = 0;
    b_hold = 0;
    for (int i = 0; i < 5000; i++) begin
      if (s_hold == 0) begin
        START = 1'($urandom_range(0, 1));
        s_hold = $urandom_range(1, 25);
      end
      s_hold--;
      if (b_hold == 0) begin
        brake = ($urandom_range(0, 3) == 0);
        b_hold = $urandom_range(1, 15);
      end
      b_hold--;
      RESET = ($urandom_range(0, 1499) != 0);
      tick(1);
    end
    RESET = 1'b1;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
